// File: rtl/hdmi_video_timing_gen.sv
// hdmi_video_timing_gen: parametrised HDMI/DVI video timing plus test-pattern source on clock50.
// Build macro HDMI_TPG_ANIM_EN adds an 8-bit frame counter that scrolls the gradient and rotates the bars.
module hdmi_video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic        clock50,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        v_clk,
    output logic        data_enable,
    output logic [23:0] rgb_data,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        frame_start
);
    localparam int unsigned CW       = 12;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;
    localparam int unsigned BW       = $clog2(BAR_W + 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [3:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    frame_mode_q, frame_mode_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          v_clk_q, v_clk_d;
    logic          de_q, de_d;
    logic [23:0]   rgb_q, rgb_d;
    logic [CW-1:0] px_q, px_d;
    logic [CW-1:0] py_q, py_d;
    logic          fs_q, fs_d;

    logic          pix_ce;
    logic          h_wrap;
    logic          v_wrap;
    logic          at_origin;
    logic          active;
    logic [1:0]    mode_eff;
    logic [23:0]   pattern;
    logic [7:0]    off;
    logic [2:0]    rot;

    // Colour of each bar in its unrotated position
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

`ifdef HDMI_TPG_ANIM_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Count completed frames at the last-pixel to first-pixel wrap
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (pix_ce && h_wrap && v_wrap) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Frame counter register
    always_ff @(posedge clock50) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign off = frame_cnt_q;
    assign rot = frame_cnt_q[7:5];
`else
    assign off = 8'd0;
    assign rot = 3'd0;
`endif

    assign pix_ce    = (div_cnt_q == DW'(CLK_DIV - 1));
    assign h_wrap    = (h_cnt_q == CW'(H_TOTAL - 1));
    assign v_wrap    = (v_cnt_q == CW'(V_TOTAL - 1));
    assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign active    = (h_cnt_q < CW'(H_ACTIVE)) && (v_cnt_q < CW'(V_ACTIVE));

    // Pattern for the current counter position; pixel (0,0) already uses the newly latched mode
    always_comb begin
        mode_eff = at_origin ? mode : frame_mode_q;
        pattern  = 24'h000000;
        case (mode_eff)
            2'd0:    pattern = bar_idx_q[3] ? 24'h000000 : bar_colour(bar_idx_q[2:0] + rot);
            2'd1:    pattern = solid_rgb;
            2'd2:    pattern = ((h_cnt_q[4:0] == 5'd0) || (v_cnt_q[4:0] == 5'd0)) ? 24'hFFFFFF : 24'h000000;
            default: pattern = {h_cnt_q[7:0] + off, v_cnt_q[7:0] + off, 8'h80};
        endcase
    end

    // Divider, raster counters, bar tracker and the pix_ce-registered output stage
    always_comb begin
        div_cnt_d    = div_cnt_q + DW'(1);
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        bar_cnt_d    = bar_cnt_q;
        bar_idx_d    = bar_idx_q;
        frame_mode_d = frame_mode_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        de_d         = de_q;
        rgb_d        = rgb_q;
        px_d         = px_q;
        py_d         = py_q;
        fs_d         = 1'b0;
        v_clk_d      = (div_cnt_q < DW'(CLK_DIV / 2));
        if (pix_ce) begin
            div_cnt_d = '0;
            fs_d      = at_origin;
            if (h_wrap) begin
                h_cnt_d   = '0;
                bar_cnt_d = '0;
                bar_idx_d = 4'd0;
                v_cnt_d   = v_wrap ? '0 : v_cnt_q + CW'(1);
            end else begin
                h_cnt_d = h_cnt_q + CW'(1);
                // Bar index saturates at 8, which paints any remainder pixels black
                if (!bar_idx_q[3]) begin
                    if (bar_cnt_q == BW'(BAR_W - 1)) begin
                        bar_cnt_d = '0;
                        bar_idx_d = bar_idx_q + 4'd1;
                    end else begin
                        bar_cnt_d = bar_cnt_q + BW'(1);
                    end
                end
            end
            if (at_origin) begin
                frame_mode_d = mode;
            end
            de_d    = active;
            hsync_d = ((h_cnt_q >= CW'(HS_START)) && (h_cnt_q < CW'(HS_END))) ? HS_POL : ~HS_POL;
            vsync_d = ((v_cnt_q >= CW'(VS_START)) && (v_cnt_q < CW'(VS_END))) ? VS_POL : ~VS_POL;
            rgb_d   = active ? pattern : 24'h000000;
            px_d    = h_cnt_q;
            py_d    = v_cnt_q;
        end
    end

    // State and output registers
    always_ff @(posedge clock50) begin
        if (reset) begin
            div_cnt_q    <= '0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= 4'd0;
            frame_mode_q <= 2'd0;
            hsync_q      <= ~HS_POL;
            vsync_q      <= ~VS_POL;
            v_clk_q      <= 1'b0;
            de_q         <= 1'b0;
            rgb_q        <= 24'h000000;
            px_q         <= '0;
            py_q         <= '0;
            fs_q         <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            bar_cnt_q    <= bar_cnt_d;
            bar_idx_q    <= bar_idx_d;
            frame_mode_q <= frame_mode_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            v_clk_q      <= v_clk_d;
            de_q         <= de_d;
            rgb_q        <= rgb_d;
            px_q         <= px_d;
            py_q         <= py_d;
            fs_q         <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign v_clk       = v_clk_q;
    assign data_enable = de_q;
    assign rgb_data    = rgb_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// tb_hdmi_video_timing_gen: two reduced-size timing generators (active-low sync with CLK_DIV=2, and
// active-high sync with CLK_DIV=3) compared every clock against a closed-form raster model.
`timescale 1ns/1ps
module tb_hdmi_video_timing_gen;
    localparam int A_HA = 66, A_HFP = 4, A_HS = 8, A_HBP = 6;
    localparam int A_VA = 36, A_VFP = 2, A_VS = 2, A_VBP = 3, A_DIV = 2;
    localparam int B_HA = 16, B_HFP = 3, B_HS = 2, B_HBP = 4;
    localparam int B_VA = 6, B_VFP = 1, B_VS = 1, B_VBP = 2, B_DIV = 3;
    localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
    localparam int A_FRAME = A_HT * (A_VA + A_VFP + A_VS + A_VBP);
    localparam int B_FRAME = (B_HA + B_HFP + B_HS + B_HBP) * (B_VA + B_VFP + B_VS + B_VBP);
    localparam int A_FRAME_CYC = A_FRAME * A_DIV;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vclk;
        logic        de;
        logic [23:0] rgb;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
    } out_t;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, div;
        bit hpol, vpol;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid_rgb = 24'h0;

    logic        hsync_a, vsync_a, vclk_a, de_a, fs_a;
    logic [23:0] rgb_a;
    logic [11:0] x_a, y_a;
    logic        hsync_b, vsync_b, vclk_b, de_b, fs_b;
    logic [23:0] rgb_b;
    logic [11:0] x_b, y_b;

    int vectors = 0;
    int errors  = 0;
    cfg_t cfg_a, cfg_b;

    int ka = 0, kb = 0;
    int fmode_a = 0, fmode_b = 0;
    logic [23:0] solid_a = 24'h0, solid_b = 24'h0;

    always #5 clk = ~clk;

    hdmi_video_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(A_DIV)
    ) dut_a (
        .clock50(clk), .reset(rst), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hsync_a), .vsync(vsync_a), .v_clk(vclk_a), .data_enable(de_a),
        .rgb_data(rgb_a), .pixel_x(x_a), .pixel_y(y_a), .frame_start(fs_a)
    );

    hdmi_video_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(B_DIV)
    ) dut_b (
        .clock50(clk), .reset(rst), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hsync_b), .vsync(vsync_b), .v_clk(vclk_b), .data_enable(de_b),
        .rgb_data(rgb_b), .pixel_x(x_b), .pixel_y(y_b), .frame_start(fs_b)
    );

    // Model bookkeeping: edges since reset release, and the inputs seen at the relevant pixel edges
    always @(posedge clk) begin
        if (rst) begin
            ka <= 0;
            kb <= 0;
        end else begin
            ka <= ka + 1;
            kb <= kb + 1;
            if ((ka + 1) % A_DIV == 0) begin
                solid_a <= solid_rgb;
                if ((((ka + 1) / A_DIV) - 1) % A_FRAME == 0) fmode_a <= int'(mode);
            end
            if ((kb + 1) % B_DIV == 0) begin
                solid_b <= solid_rgb;
                if ((((kb + 1) / B_DIV) - 1) % B_FRAME == 0) fmode_b <= int'(mode);
            end
        end
    end

    function automatic logic [23:0] bar_col(input int i);
        case (i)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected outputs after the k-th clock edge since reset release (k=0: in reset)
    function automatic out_t model(input cfg_t c, input int k, input int fmode, input logic [23:0] solid);
        out_t o;
        int ht, vt, p, pf, fnum, x, y, bar, off;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        o = '0;
        o.hs = ~c.hpol;
        o.vs = ~c.vpol;
        o.vclk = (k > 0) && (((k - 1) % c.div) < (c.div / 2));
        if (k < c.div) return o;
        p    = k / c.div - 1;
        pf   = p % (ht * vt);
        fnum = p / (ht * vt);
        x    = pf % ht;
        y    = pf / ht;
        o.x  = 12'(x);
        o.y  = 12'(y);
        o.de = (x < c.ha) && (y < c.va);
        o.hs = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hs) ? c.hpol : ~c.hpol;
        o.vs = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vs) ? c.vpol : ~c.vpol;
        o.fs = (k % c.div == 0) && (pf == 0);
`ifdef HDMI_TPG_ANIM_EN
        off = fnum % 256;
`else
        off = 0;
`endif
        if (o.de) begin
            case (fmode)
                0: begin
                    bar = x / (c.ha / 8);
                    o.rgb = (bar >= 8) ? 24'h000000 : bar_col((bar + off / 32) % 8);
                end
                1: o.rgb = solid;
                2: o.rgb = ((x % 32 == 0) || (y % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
                default: o.rgb = {8'((x + off) % 256), 8'((y + off) % 256), 8'h80};
            endcase
        end
        return o;
    endfunction

    function automatic out_t act_a();
        return {hsync_a, vsync_a, vclk_a, de_a, rgb_a, x_a, y_a, fs_a};
    endfunction

    function automatic out_t act_b();
        return {hsync_b, vsync_b, vclk_b, de_b, rgb_b, x_b, y_b, fs_b};
    endfunction

    task automatic test_reset();
        out_t ra, rb, oa, ob;
        rst = 1'b1;
        mode = 2'd0;
        ra = '0; ra.hs = 1'b1; ra.vs = 1'b1;
        rb = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            oa = act_a(); ob = act_b();
            vectors++;
            if (oa !== ra) begin errors++; $display("FAIL reset_a cyc=%0d got %h want %h", i, oa, ra); end
            vectors++;
            if (ob !== rb) begin errors++; $display("FAIL reset_b cyc=%0d got %h want %h", i, ob, rb); end
        end
        rst = 1'b0;
    endtask

    task automatic test_bars();
        out_t ea, eb, oa, ob;
        mode = 2'd0;
        for (int i = 0; i < A_FRAME_CYC + 200; i++) begin
            @(negedge clk);
            ea = model(cfg_a, ka, fmode_a, solid_a); oa = act_a();
            eb = model(cfg_b, kb, fmode_b, solid_b); ob = act_b();
            vectors++;
            if (oa !== ea) begin errors++; $display("FAIL bars_a k=%0d got %h want %h", ka, oa, ea); end
            vectors++;
            if (ob !== eb) begin errors++; $display("FAIL bars_b k=%0d got %h want %h", kb, ob, eb); end
        end
    endtask

    task automatic test_mode_switch();
        out_t ea, eb, oa, ob;
        mode = 2'd0;
        for (int i = 0; i < 2 * A_FRAME_CYC; i++) begin
            @(negedge clk);
            ea = model(cfg_a, ka, fmode_a, solid_a); oa = act_a();
            eb = model(cfg_b, kb, fmode_b, solid_b); ob = act_b();
            vectors++;
            if (oa !== ea) begin errors++; $display("FAIL switch_a k=%0d got %h want %h", ka, oa, ea); end
            vectors++;
            if (ob !== eb) begin errors++; $display("FAIL switch_b k=%0d got %h want %h", kb, ob, eb); end
            if (i == 10 * A_HT * A_DIV) mode = 2'd2;
        end
    endtask

    task automatic test_gradient();
        out_t ea, eb, oa, ob;
        mode = 2'd3;
        for (int i = 0; i < A_FRAME_CYC + 500; i++) begin
            @(negedge clk);
            ea = model(cfg_a, ka, fmode_a, solid_a); oa = act_a();
            eb = model(cfg_b, kb, fmode_b, solid_b); ob = act_b();
            vectors++;
            if (oa !== ea) begin errors++; $display("FAIL gradient_a k=%0d got %h want %h", ka, oa, ea); end
            vectors++;
            if (ob !== eb) begin errors++; $display("FAIL gradient_b k=%0d got %h want %h", kb, ob, eb); end
        end
    endtask

    task automatic test_random();
        out_t ea, eb, oa, ob;
        mode = 2'd1;
        for (int i = 0; i < A_FRAME_CYC + A_FRAME_CYC / 2; i++) begin
            @(negedge clk);
            ea = model(cfg_a, ka, fmode_a, solid_a); oa = act_a();
            eb = model(cfg_b, kb, fmode_b, solid_b); ob = act_b();
            vectors++;
            if (oa !== ea) begin errors++; $display("FAIL random_a k=%0d got %h want %h", ka, oa, ea); end
            vectors++;
            if (ob !== eb) begin errors++; $display("FAIL random_b k=%0d got %h want %h", kb, ob, eb); end
            solid_rgb = 24'($urandom);
            if ($urandom_range(0, 499) == 0) mode = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_frame();
        out_t ea, eb, oa, ob;
        int p, pf, n;
        bit found;
        found = 1'b0;
        mode = 2'd0;
        for (int i = 0; i < A_FRAME_CYC + 10 && !found; i++) begin
            @(negedge clk);
            ea = model(cfg_a, ka, fmode_a, solid_a); oa = act_a();
            eb = model(cfg_b, kb, fmode_b, solid_b); ob = act_b();
            vectors++;
            if (oa !== ea) begin errors++; $display("FAIL midrst_wait_a k=%0d got %h want %h", ka, oa, ea); end
            vectors++;
            if (ob !== eb) begin errors++; $display("FAIL midrst_wait_b k=%0d got %h want %h", kb, ob, eb); end
            p  = ka / A_DIV - 1;
            pf = p % A_FRAME;
            if (ka >= A_DIV && pf == 20 * A_HT + 30) found = 1'b1;
        end
        vectors++;
        if (!found) begin errors++; $display("FAIL midrst_locate got none want line 20 x 30"); end
        rst = 1'b1;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n + 1500; i++) begin
            @(negedge clk);
            if (i == n) rst = 1'b0;
            ea = model(cfg_a, ka, fmode_a, solid_a); oa = act_a();
            eb = model(cfg_b, kb, fmode_b, solid_b); ob = act_b();
            vectors++;
            if (oa !== ea) begin errors++; $display("FAIL midrst_a k=%0d got %h want %h", ka, oa, ea); end
            vectors++;
            if (ob !== eb) begin errors++; $display("FAIL midrst_b k=%0d got %h want %h", kb, ob, eb); end
        end
    endtask

    initial begin
        cfg_a.ha = A_HA; cfg_a.hfp = A_HFP; cfg_a.hs = A_HS; cfg_a.hbp = A_HBP;
        cfg_a.va = A_VA; cfg_a.vfp = A_VFP; cfg_a.vs = A_VS; cfg_a.vbp = A_VBP;
        cfg_a.div = A_DIV; cfg_a.hpol = 1'b0; cfg_a.vpol = 1'b0;
        cfg_b.ha = B_HA; cfg_b.hfp = B_HFP; cfg_b.hs = B_HS; cfg_b.hbp = B_HBP;
        cfg_b.va = B_VA; cfg_b.vfp = B_VFP; cfg_b.vs = B_VS; cfg_b.vbp = B_VBP;
        cfg_b.div = B_DIV; cfg_b.hpol = 1'b1; cfg_b.vpol = 1'b1;
        test_reset();
        test_bars();
        test_mode_switch();
        test_gradient();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
